s2_demux_reg: RTL and testbench
===============================

// Module: s2_demux_reg
// PURPOSE
//  Registered 1-to-4 demultiplexer: the write-side counterpart of the S2 mux/flip-flop cell.
//  Routes one data lane onto four held outputs Q00..Q11, addressed by the same A/B select pins S2 uses.
//  Also has an auto mode that deserialises 4 beats into Q00..Q11 and commits them in one update.
//  Sits in front of S2 instances and drives their D00..D11 inputs from a serial source.
// PARAMETERS
//  WIDTH  1  bits per lane (din and each Q)
// PORTS
//  clk         in   1      rising-edge clock
//  clr         in   1      asynchronous active-low clear
//  din         in   WIDTH  write data
//  we          in   1      write/beat strobe, sampled on posedge clk
//  auto        in   1      1 = frame (deserialise) mode, 0 = direct addressed mode
//  A0,A1       in   1      select low bit: sel_lo = A0 & A1
//  B0,B1       in   1      select high bit: sel_hi = B0 | B1
//  Q00,Q01,Q10,Q11 out WIDTH  held outputs, index {sel_hi,sel_lo}
//  busy        out  1      frame in progress (state != IDLE)
//  frame_done  out  1      one-cycle pulse: frame committed to Q
//  perr        out  1      one-cycle pulse: parity mismatch (0 unless macro)
// BEHAVIOUR
//  Reset (clr=0, async): Q* = 0, shadow = 0, ptr = 0, state = IDLE, busy/frame_done/perr = 0.
//  Direct mode (auto=0, state IDLE): on an edge with we=1, Q{sel_hi,sel_lo} <= din; the other
//   three outputs hold. Latency is 1 cycle. we=0 holds all outputs.
//  Auto mode FSM, ptr is 2 bits:
//   IDLE: auto=1 & we=1 -> shadow[0]<=din, ptr<=1, go to FILL. A/B are ignored in auto mode.
//   FILL: we=1 -> shadow[ptr]<=din, ptr++. we=0 stalls with no change.
//     Beat with ptr==3 & we=1: Q00..Q11 <= {shadow0..2,din} all on the same edge;
//     frame_done=1 for the next cycle; ptr<=0; state -> IDLE.
//   Back-to-back frames: a new first beat is accepted in the cycle frame_done is high.
//  Beat order: beat0->Q00, beat1->Q01, beat2->Q10, beat3->Q11.
//  auto falls while in FILL: abort. Discard shadow, ptr<=0, go to IDLE.
//   Q unchanged and no frame_done. Direct-mode writes resume on the following cycle.
//  Direct write and auto=1 together: the auto rule wins; no direct write occurs.
//  Outputs of the frame FSM are registered; Q never shows a partial frame.
//  clr asserted mid-frame: immediate reset values, partial frame lost.
// CONFIGURATION
//  S2_DEMUX_PARITY_EN defined: FILL is followed by a PAR state expecting a 5th beat.
//   The 5th beat (we=1) carries even parity in din[0] = XOR of all 4*WIDTH frame bits.
//   Match: commit Q and pulse frame_done. Mismatch: Q unchanged and pulse perr.
//   Either way go to IDLE. busy is held through PAR. An auto drop in PAR aborts as in FILL.
//  Not defined: 4-beat frames only; perr is tied to 0; no PAR state.
// TESTING
//  Reset: clr=0 mid-run -> Q*=0, busy=0 with no clock edge needed.
//  Direct mode, WIDTH=1:
//   A0=1,A1=1,B0=0,B1=0,din=1,we=1 for 1 cycle -> Q01=1, other Q=0.
//   Then B1=1,din=1 -> Q11=1, Q01 still 1.
//  Frame: auto=1, beats 1,0,1,1 with we=1 each cycle -> after beat 4: Q00=1,Q01=0,Q10=1,Q11=1,
//   frame_done high exactly 1 cycle; Q unchanged (prior values) during beats 1-3.
//  Stall/abort:
//   beats 1,1 then we=0 for 3 cycles then 0,0 -> commit 1,1,0,0.
//   Separately, drop auto after 2 beats -> Q unchanged, busy=0, no frame_done.
//  Parity (macro on): frame 1,0,1,1 + parity 1 -> commit and frame_done.
//   Same frame + parity 0 -> perr pulse, Q unchanged.
//   Back-to-back frames with no idle cycle must both commit.

Source files
------------

// File: rtl/s2_demux_reg.sv
// Registered 1-to-4 demultiplexer with a 4-beat deserialising frame mode.
// Optional even-parity fifth beat when S2_DEMUX_PARITY_EN is defined.
module s2_demux_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             we,
  input  logic             auto,
  input  logic             A0,
  input  logic             A1,
  input  logic             B0,
  input  logic             B1,
  output logic [WIDTH-1:0] Q00,
  output logic [WIDTH-1:0] Q01,
  output logic [WIDTH-1:0] Q10,
  output logic [WIDTH-1:0] Q11,
  output logic             busy,
  output logic             frame_done,
  output logic             perr
);

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned NUM_SHADOW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1
`ifdef S2_DEMUX_PARITY_EN
    ,
    PAR  = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] q_q[NUM_OUT];
  logic [WIDTH-1:0] q_d[NUM_OUT];
  logic [WIDTH-1:0] shadow_q[NUM_SHADOW];
  logic [WIDTH-1:0] shadow_d[NUM_SHADOW];
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [1:0]       sel_c;

  assign sel_c = {B0 | B1, A0 & A1};

`ifdef S2_DEMUX_PARITY_EN
  logic [WIDTH-1:0] last_q, last_d;
  logic             perr_q, perr_d;
  logic             par_ok_c;

  // Even parity over every bit of the four captured beats.
  assign par_ok_c = (din[0] == ^{shadow_q[0], shadow_q[1], shadow_q[2], last_q});
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    q_d          = q_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
`ifdef S2_DEMUX_PARITY_EN
    last_d       = last_q;
    perr_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (auto && we) begin
          shadow_d[0] = din;
          ptr_d       = 2'd1;
          state_d     = FILL;
        end else if (!auto && we) begin
          q_d[sel_c] = din;
        end
      end

      FILL: begin
        if (!auto) begin
          for (int i = 0; i < NUM_SHADOW; i++) shadow_d[i] = '0;
          ptr_d   = 2'd0;
          state_d = IDLE;
        end else if (we) begin
          if (ptr_q == 2'd3) begin
            ptr_d = 2'd0;
`ifdef S2_DEMUX_PARITY_EN
            last_d  = din;
            state_d = PAR;
`else
            q_d[0]       = shadow_q[0];
            q_d[1]       = shadow_q[1];
            q_d[2]       = shadow_q[2];
            q_d[3]       = din;
            frame_done_d = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            shadow_d[ptr_q] = din;
            ptr_d           = ptr_q + 2'd1;
          end
        end
      end

`ifdef S2_DEMUX_PARITY_EN
      PAR: begin
        if (!auto) begin
          for (int i = 0; i < NUM_SHADOW; i++) shadow_d[i] = '0;
          last_d  = '0;
          ptr_d   = 2'd0;
          state_d = IDLE;
        end else if (we) begin
          if (par_ok_c) begin
            q_d[0]       = shadow_q[0];
            q_d[1]       = shadow_q[1];
            q_d[2]       = shadow_q[2];
            q_d[3]       = last_q;
            frame_done_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif

      default: begin
        ptr_d   = 2'd0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) q_q[i] <= '0;
      for (int i = 0; i < NUM_SHADOW; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      q_q          <= q_d;
      shadow_q     <= shadow_d;
    end
  end

`ifdef S2_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      last_q <= '0;
      perr_q <= 1'b0;
    end else begin
      last_q <= last_d;
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign Q00        = q_q[0];
  assign Q01        = q_q[1];
  assign Q10        = q_q[2];
  assign Q11        = q_q[3];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_s2_demux_reg.sv
// Scoreboard bench for s2_demux_reg: a behavioural model queues the expected
// outputs per driven cycle and each entry is popped and compared after the edge.
module tb_s2_demux_reg;

  localparam int unsigned W = 1;
  localparam int unsigned VW = 4 * W + 3;

  logic         clk = 1'b0;
  logic         clr;
  logic [W-1:0] din;
  logic         we, auto, A0, A1, B0, B1;
  logic [W-1:0] Q00, Q01, Q10, Q11;
  logic         busy, frame_done, perr;

  int n_tests = 0;
  int n_fail  = 0;

  s2_demux_reg #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .din(din), .we(we), .auto(auto),
    .A0(A0), .A1(A1), .B0(B0), .B1(B1),
    .Q00(Q00), .Q01(Q01), .Q10(Q10), .Q11(Q11),
    .busy(busy), .frame_done(frame_done), .perr(perr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_q[4];
  logic [W-1:0] m_beat[4];
  int           m_state;  // 0 idle, 1 collecting beats, 2 awaiting parity
  int           m_cnt;
  logic         m_fd, m_perr;
  logic [VW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {Q00, Q01, Q10, Q11, busy, frame_done, perr};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_q[0], m_q[1], m_q[2], m_q[3], m_state != 0, m_fd, m_perr};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i] = '0;
      m_beat[i] = '0;
    end
    m_state = 0;
    m_cnt   = 0;
    m_fd    = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] d, input logic w, input logic au,
                            input logic a0, input logic a1, input logic b0, input logic b1);
    logic [W-1:0] pbits;
    m_fd   = 1'b0;
    m_perr = 1'b0;
    if (m_state == 0) begin
      if (au && w) begin
        m_beat[0] = d;
        m_cnt     = 1;
        m_state   = 1;
      end else if (w) begin
        m_q[{b0 | b1, a0 & a1}] = d;
      end
    end else if (!au) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (w) begin
      if (m_state == 1) begin
        m_beat[m_cnt] = d;
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt = 0;
`ifdef S2_DEMUX_PARITY_EN
          m_state = 2;
`else
          for (int i = 0; i < 4; i++) m_q[i] = m_beat[i];
          m_fd    = 1'b1;
          m_state = 0;
`endif
        end
      end else begin
        pbits = m_beat[0] ^ m_beat[1] ^ m_beat[2] ^ m_beat[3];
        if (d[0] == ^pbits) begin
          for (int i = 0; i < 4; i++) m_q[i] = m_beat[i];
          m_fd = 1'b1;
        end else begin
          m_perr = 1'b1;
        end
        m_state = 0;
      end
    end
  endtask

  // Drive one cycle at the falling edge, queue the expectation, check after the rising edge.
  task automatic cyc(input logic [W-1:0] d, input logic w, input logic au,
                     input logic a0, input logic a1, input logic b0, input logic b1);
    logic [VW-1:0] e;
    @(negedge clk);
    din = d; we = w; auto = au; A0 = a0; A1 = a1; B0 = b0; B1 = b1;
    model_step(d, w, au, a0, a1, b0, b1);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("cyc", 32'(obs_vec()), 32'(e));
    end
  endtask

  task automatic beat(input logic [W-1:0] d);
    cyc(d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [3:0] qv();
    return {Q00[0], Q01[0], Q10[0], Q11[0]};
  endfunction

  initial begin
    clr = 1'b0; din = '0; we = 1'b0; auto = 1'b0;
    A0 = 1'b0; A1 = 1'b0; B0 = 1'b0; B1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(obs_vec()), 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Direct addressed writes
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("dir_q01", 32'(qv()), 32'b0100);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("dir_q11", 32'(qv()), 32'b0101);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dir_hold", 32'(qv()), 32'b0101);
    for (int i = 0; i < 12; i++)
      cyc(W'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom));
    // Restore known Q contents: 0,1,0,1
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("dir_restore", 32'(qv()), 32'b0101);

    // Frame 1,0,1,1 ; A/B set to show they are ignored in auto mode
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("frm_busy", 32'(busy), 32'd1);
    chk("frm_no_partial", 32'(qv()), 32'b0101);
    beat(1'b0);
    beat(1'b1);
    beat(1'b1);
`ifdef S2_DEMUX_PARITY_EN
    chk("par_wait_q", 32'(qv()), 32'b0101);
    beat(1'b1);
`endif
    chk("frm_commit", 32'(qv()), 32'b1011);
    chk("frm_done", 32'(frame_done), 32'd1);
    idle();
    chk("frm_done_1cyc", 32'(frame_done), 32'd0);

    // Stall: 1,1, three idle cycles, 0,0
    beat(1'b1);
    beat(1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b0);
    beat(1'b0);
`ifdef S2_DEMUX_PARITY_EN
    beat(1'b0);
`endif
    chk("stall_commit", 32'(qv()), 32'b1100);

    // Abort after two beats, then a direct write on the next cycle
    beat(1'b0);
    beat(1'b1);
    idle();
    chk("abort_q", 32'(qv()), 32'b1100);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(frame_done), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_abort_dir", 32'(qv()), 32'b1101);

    // Back-to-back frames: 0,1,1,0 then 1,0,0,1 with no idle cycle
    beat(1'b0); beat(1'b1); beat(1'b1); beat(1'b0);
`ifdef S2_DEMUX_PARITY_EN
    beat(1'b0);
`endif
    chk("b2b_first", 32'(qv()), 32'b0110);
    beat(1'b1);
    chk("b2b_accept", 32'(busy), 32'd1);
    beat(1'b0); beat(1'b0); beat(1'b1);
`ifdef S2_DEMUX_PARITY_EN
    beat(1'b0);
`endif
    chk("b2b_second", 32'(qv()), 32'b1001);

`ifdef S2_DEMUX_PARITY_EN
    // Bad parity: Q unchanged, perr pulse
    beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b1);
    beat(1'b0);
    chk("perr_pulse", 32'(perr), 32'd1);
    chk("perr_q", 32'(qv()), 32'b1001);
    idle();
    chk("perr_1cyc", 32'(perr), 32'd0);
    // Abort in the parity state
    beat(1'b1); beat(1'b1); beat(1'b1); beat(1'b1);
    idle();
    chk("par_abort", 32'(qv()), 32'b1001);
`endif

    // Random mixed traffic against the model
    for (int i = 0; i < 80; i++)
      cyc(W'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // Asynchronous clear mid-frame
    idle();
    beat(1'b1);
    beat(1'b1);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_async", 32'(obs_vec()), 32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b1;
    idle();
    chk("clr_after", 32'(obs_vec()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
